// File: rtl/interval_timer_pkg.sv
// interval_timer_pkg: register map, bit indices and control-register type shared by the timer files.
// Rev 1.0
`default_nettype none
package interval_timer_pkg;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
  localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
  localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

  localparam int CTRL_STOP  = 3;
  localparam int CTRL_START = 2;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_ITO   = 0;
  localparam int STAT_RUN   = 1;
  localparam int STAT_TO    = 0;

  typedef struct packed {
    logic cont;
    logic ito;
  } ctrl_reg_t;

endpackage
`default_nettype wire

// File: rtl/interval_timer_param_if.sv
// interval_timer_param_if: 16-bit Avalon-MM slave bus plus level IRQ for the interval timer.
// Rev 1.0
`default_nettype none
interface interval_timer_param_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;

  modport master (output address, chipselect, write_n, writedata, input readdata, irq);
  modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface
`default_nettype wire

// File: rtl/interval_timer_core.sv
// interval_timer_core: down-counter with reload, RUN control and zero-edge timeout detection.
// Rev 1.0
`default_nettype none
module interval_timer_core
  import interval_timer_pkg::*;
#(
  parameter int                       COUNTER_WIDTH = 32,
  parameter logic [COUNTER_WIDTH-1:0] RESET_COUNT   = '0,
  parameter bit                       RESET_RUNNING = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [COUNTER_WIDTH-1:0] i_period,
  input  logic                     i_force_reload,
  input  logic                     i_start,
  input  logic                     i_stop,
  input  logic                     i_cont,
  output logic [COUNTER_WIDTH-1:0] o_count,
  output logic                     o_run,
  output logic                     o_timeout_evt
);

  logic [COUNTER_WIDTH-1:0] r_count;
  logic                     r_run;
  logic                     r_zero_d;
  logic                     w_zero;

  assign w_zero        = (r_count == '0);
  // Qualifying with the delayed zero keeps a period-0 or parked-at-zero counter to one event.
  assign o_timeout_evt = r_run & w_zero & ~r_zero_d;
  assign o_count       = r_count;
  assign o_run         = r_run;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count  <= RESET_COUNT;
      r_run    <= RESET_RUNNING;
      r_zero_d <= 1'b0;
    end else begin
      r_zero_d <= w_zero;
      if (i_force_reload) begin
        r_count <= i_period;
        r_run   <= 1'b0;
      end else begin
        if (r_run) begin
          if (w_zero) r_count <= i_period;
          else        r_count <= r_count - COUNTER_WIDTH'(1);
        end
        if (i_stop)                        r_run <= 1'b0;
        else if (i_start)                  r_run <= 1'b1;
        else if (r_run && w_zero && !i_cont) r_run <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/interval_timer_param.sv
// interval_timer_param: parametrised Avalon-MM interval timer (decode, registers, snapshot, read mux).
// Optional timeout_pulse output via INTERVAL_TIMER_PULSE_OUT_EN. Rev 1.0
`default_nettype none
module interval_timer_param
  import interval_timer_pkg::*;
#(
  parameter int          COUNTER_WIDTH = 32,
  parameter logic [31:0] RESET_PERIOD  = 32'h0001_869F,
  parameter bit          RESET_RUNNING = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
`ifdef INTERVAL_TIMER_PULSE_OUT_EN
  output logic timeout_pulse,
`endif
  interval_timer_param_if.slave bus
);

  localparam int               CW             = COUNTER_WIDTH;
  localparam logic [CW-1:0]    c_reset_period = RESET_PERIOD[CW-1:0];
  localparam ctrl_reg_t        c_ctrl_reset   = '{cont: 1'b1, ito: 1'b0};

  logic [CW-1:0] r_period;
  logic [CW-1:0] r_snap;
  ctrl_reg_t     r_ctrl;
  logic          r_to;
  logic          r_force_reload;
  logic [15:0]   r_readdata;

  logic          w_wr, w_wr_status, w_wr_control, w_wr_period_l, w_wr_period_h, w_wr_snap_l;
  logic          w_start, w_stop, w_run, w_evt;
  logic [CW-1:0] w_count;
  logic [15:0]   w_rdata, w_period_h, w_snap_h;

  assign w_wr          = bus.chipselect & ~bus.write_n;
  assign w_wr_status   = w_wr & (bus.address == ADDR_STATUS);
  assign w_wr_control  = w_wr & (bus.address == ADDR_CONTROL);
  assign w_wr_period_l = w_wr & (bus.address == ADDR_PERIOD_L);
  assign w_wr_period_h = w_wr & (bus.address == ADDR_PERIOD_H);
  assign w_wr_snap_l   = w_wr & (bus.address == ADDR_SNAP_L);
  assign w_start       = w_wr_control & bus.writedata[CTRL_START];
  assign w_stop        = w_wr_control & bus.writedata[CTRL_STOP];

  interval_timer_core #(
    .COUNTER_WIDTH (CW),
    .RESET_COUNT   (c_reset_period),
    .RESET_RUNNING (RESET_RUNNING)
  ) u_core (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_period       (r_period),
    .i_force_reload (r_force_reload),
    .i_start        (w_start),
    .i_stop         (w_stop),
    .i_cont         (r_ctrl.cont),
    .o_count        (w_count),
    .o_run          (w_run),
    .o_timeout_evt  (w_evt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_period       <= c_reset_period;
      r_snap         <= '0;
      r_ctrl         <= c_ctrl_reset;
      r_to           <= 1'b0;
      r_force_reload <= 1'b0;
      r_readdata     <= '0;
    end else begin
      // The counter picks up a new period one cycle later, once the register holds it.
      r_force_reload <= w_wr_period_l | w_wr_period_h;
      if (w_wr_period_l) r_period[15:0]    <= bus.writedata;
      if (w_wr_period_h) r_period[CW-1:16] <= bus.writedata[CW-17:0];
      if (w_wr_control) begin
        r_ctrl.cont <= bus.writedata[CTRL_CONT];
        r_ctrl.ito  <= bus.writedata[CTRL_ITO];
      end
      if (w_evt)            r_to <= 1'b1;
      else if (w_wr_status) r_to <= 1'b0;
      if (w_wr_snap_l) r_snap <= w_count;
      r_readdata <= w_rdata;
    end
  end

  always_comb begin
    w_period_h = '0;
    w_snap_h   = '0;
    w_rdata    = '0;
    w_period_h[CW-17:0] = r_period[CW-1:16];
    w_snap_h[CW-17:0]   = r_snap[CW-1:16];
    case (bus.address)
      ADDR_STATUS: begin
        w_rdata[STAT_RUN] = w_run;
        w_rdata[STAT_TO]  = r_to;
      end
      ADDR_CONTROL: begin
        w_rdata[CTRL_CONT] = r_ctrl.cont;
        w_rdata[CTRL_ITO]  = r_ctrl.ito;
      end
      ADDR_PERIOD_L: w_rdata = r_period[15:0];
      ADDR_PERIOD_H: w_rdata = w_period_h;
      ADDR_SNAP_L:   w_rdata = r_snap[15:0];
      ADDR_SNAP_H:   w_rdata = w_snap_h;
      default:       w_rdata = '0;
    endcase
  end

  assign bus.readdata = r_readdata;
  assign bus.irq      = r_to & r_ctrl.ito;

`ifdef INTERVAL_TIMER_PULSE_OUT_EN
  logic r_pulse;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_pulse <= 1'b0;
    else          r_pulse <= w_evt;
  end
  assign timeout_pulse = r_pulse;
`endif

endmodule
`default_nettype wire

// File: tb/tb_interval_timer_param.sv
// tb_interval_timer_param: self-checking bench for interval_timer_param (COUNTER_WIDTH=20, short reset period).
// Rev 1.0
`default_nettype none
module tb_interval_timer_param;
  import interval_timer_pkg::*;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;

  interval_timer_param_if bus();

`ifdef INTERVAL_TIMER_PULSE_OUT_EN
  logic timeout_pulse;
  logic pulse_prev = 1'b0;
`endif

  interval_timer_param #(
    .COUNTER_WIDTH (20),
    .RESET_PERIOD  (32'hFFF0_4E1F),
    .RESET_RUNNING (1'b1)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
`ifdef INTERVAL_TIMER_PULSE_OUT_EN
    .timeout_pulse (timeout_pulse),
`endif
    .bus           (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
`ifdef INTERVAL_TIMER_PULSE_OUT_EN
    pulse_prev = timeout_pulse;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic sb_pop();
    sb_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_underflow: got no entry expected one");
    end else begin
      e = sb_q.pop_front();
      chk(e.name, {16'h0, bus.readdata}, {16'h0, e.exp});
    end
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string name);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    tick();
    bus.chipselect = 1'b0;
    sb_pop();
  endtask

  // Watch STATUS.TO through readdata (one-cycle registered latency) and check its arrival edge.
  task automatic poll_to(input int exp_cyc, input int bound, input string name);
    int n;
    n = 0;
    bus.address    = ADDR_STATUS;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    do begin
      tick();
      n++;
    end while (bus.readdata[STAT_TO] !== 1'b1 && n < bound);
    if (bus.readdata[STAT_TO] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: got no TO within %0d cycles expected TO at cycle %0d", name, bound, exp_cyc);
    end else begin
      chk(name, cyc, exp_cyc);
`ifdef INTERVAL_TIMER_PULSE_OUT_EN
      chk({name, "_pulse"}, {30'h0, pulse_prev, timeout_pulse}, 32'h2);
`endif
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, s, p, q, w, frozen, expv;

    vecs[0] = '{ADDR_PERIOD_L, 16'hABCD, 16'hABCD, "tbl_period_l"};
    vecs[1] = '{ADDR_PERIOD_H, 16'hFFFF, 16'h000F, "tbl_period_h_trunc"};
    vecs[2] = '{ADDR_CONTROL,  16'h0003, 16'h0003, "tbl_ctrl_cont_ito"};
    vecs[3] = '{ADDR_CONTROL,  16'h000E, 16'h0002, "tbl_ctrl_wo_bits"};
    vecs[4] = '{ADDR_CONTROL,  16'h0000, 16'h0000, "tbl_ctrl_zero"};
    vecs[5] = '{3'd6,          16'h1234, 16'h0000, "tbl_addr6"};
    vecs[6] = '{3'd7,          16'hFFFF, 16'h0000, "tbl_addr7"};
    vecs[7] = '{ADDR_STATUS,   16'hFFFF, 16'h0000, "tbl_status_idle"};

    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_readdata", {16'h0, bus.readdata}, 32'h0);
    chk("rst_irq", {31'h0, bus.irq}, 32'h0);

    // Default free-run: period 19999 gives TO 20000 clocks after release.
    @(negedge clk);
    reset_n = 1'b1;
    t0 = cyc;
    poll_to(t0 + 20001, 20100, "default_to_time");
    chk("default_irq_off", {31'h0, bus.irq}, 32'h0);
    wr(ADDR_CONTROL, 16'h0003);
    chk("ito_irq_on", {31'h0, bus.irq}, 32'h1);

    // One-shot, period 9.
    wr(ADDR_PERIOD_L, 16'd9);
    wr(ADDR_PERIOD_H, 16'd0);
    wr(ADDR_STATUS, 16'h0);
    wr(ADDR_CONTROL, 16'h0004);
    s = cyc;
    poll_to(s + 11, 40, "p9_to_time");
    rd(ADDR_STATUS, 16'h0001, "p9_status_run0");
    wr(ADDR_SNAP_L, 16'h0);
    rd(ADDR_SNAP_L, 16'd9, "p9_counter_hold");
    rd(ADDR_SNAP_H, 16'd0, "p9_snap_h");

    // Continuous, period 4: events every 5 clocks.
    wr(ADDR_PERIOD_L, 16'd4);
    wr(ADDR_STATUS, 16'h0);
    wr(ADDR_CONTROL, 16'h0006);
    s = cyc;
    poll_to(s + 6, 40, "p4_to_first");
    wr(ADDR_STATUS, 16'h0);
    rd(ADDR_STATUS, 16'h0002, "p4_to_cleared");
    poll_to(s + 11, 40, "p4_to_second");
    while (cyc < s + 14) tick();
    wr(ADDR_STATUS, 16'h0);
    rd(ADDR_STATUS, 16'h0003, "p4_coincident_to");

    // Asynchronous reset mid-count with irq asserted.
    wr(ADDR_CONTROL, 16'h0003);
    chk("irq_before_reset", {31'h0, bus.irq}, 32'h1);
    rd(ADDR_CONTROL, 16'h0003, "ctrl_readback");
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_irq", {31'h0, bus.irq}, 32'h0);
    chk("async_rst_readdata", {16'h0, bus.readdata}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    wr(ADDR_SNAP_L, 16'h0);
    rd(ADDR_SNAP_L, 16'h4E1F, "rst_counter_l");
    rd(ADDR_SNAP_H, 16'h0000, "rst_counter_h");
    rd(ADDR_STATUS, 16'h0002, "rst_status_run_to0");
    rd(ADDR_CONTROL, 16'h0002, "rst_control");
    rd(ADDR_PERIOD_L, 16'h4E1F, "rst_period_l");
    rd(ADDR_PERIOD_H, 16'h0000, "rst_period_h");

    // Snapshot of a running counter.
    wr(ADDR_PERIOD_L, 16'h2400);
    wr(ADDR_PERIOD_H, 16'h0001);
    tick();
    wr(ADDR_CONTROL, 16'h0006);
    s = cyc;
    repeat (187) tick();
    wr(ADDR_SNAP_L, 16'h0);
    rd(ADDR_SNAP_L, 16'h2345, "snap_l");
    rd(ADDR_SNAP_H, 16'h0001, "snap_h");
    wr(ADDR_SNAP_L, 16'h0);
    w = cyc;
    expv = 32'h12400 - (w - 1 - s);
    rd(ADDR_SNAP_L, 16'(expv), "snap_l_later");

    // START|STOP together: STOP wins and the counter freezes; START resumes.
    wr(ADDR_CONTROL, 16'h000C);
    p = cyc;
    frozen = 32'h12400 - (p - s);
    rd(ADDR_STATUS, 16'h0000, "stop_run0");
    repeat (3) tick();
    wr(ADDR_SNAP_L, 16'h0);
    rd(ADDR_SNAP_L, 16'(frozen), "frozen_l");
    rd(ADDR_SNAP_H, 16'(frozen >> 16), "frozen_h");
    wr(ADDR_CONTROL, 16'h0006);
    q = cyc;
    repeat (4) tick();
    wr(ADDR_SNAP_L, 16'h0);
    w = cyc;
    expv = frozen - (w - 1 - q);
    rd(ADDR_SNAP_L, 16'(expv), "resume_l");

    for (int i = 0; i < 8; i++) begin
      wr(vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].addr, vecs[i].exp, vecs[i].name);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
